// File: rtl/codec_volume_ctrl_if.sv
// Manual-write handshake between the volume controller and the codec init/manual-write block:
// one-cycle send pulse with register/data, answered by a one-cycle done pulse.
interface codec_volume_ctrl_if;
    logic       manualSend;
    logic [6:0] manualRegister;
    logic [8:0] manualData;
    logic       manualDone;

    modport master (
        output manualSend,
        output manualRegister,
        output manualData,
        input  manualDone
    );

    modport slave (
        input  manualSend,
        input  manualRegister,
        input  manualData,
        output manualDone
    );
endinterface

// File: rtl/codec_volume_ctrl.sv
// Turns volume up/down and mute-toggle pulses into single codec register writes, merging bursts.
// Optional macro VOLCTRL_ZEROCROSS_EN sets LZCEN (data bit 7) on volume writes.
module codec_volume_ctrl #(
    parameter logic [6:0]  VOL_DEFAULT = 7'h79,
    parameter logic [6:0]  VOL_MIN     = 7'h30,
    parameter logic [6:0]  VOL_MAX     = 7'h7F,
    parameter logic [6:0]  VOL_STEP    = 7'd2,
    parameter int unsigned HOLDOFF     = 50000,
    parameter int unsigned TIMEOUT     = 2000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                initDone,
    input  logic                volUp,
    input  logic                volDown,
    input  logic                muteToggle,
    codec_volume_ctrl_if.master wr,
    output logic [6:0]          volume,
    output logic                muted,
    output logic                busy,
    output logic                wrError
);

    localparam int unsigned CNT_MAX = (TIMEOUT > HOLDOFF) ? TIMEOUT : HOLDOFF;
    localparam int          CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF - 1);
    localparam logic [6:0]  REG_VOLUME = 7'h02;
    localparam logic [6:0]  REG_MUTE   = 7'h05;
`ifdef VOLCTRL_ZEROCROSS_EN
    localparam logic        ZC_BIT     = 1'b1;
`else
    localparam logic        ZC_BIT     = 1'b0;
`endif

    typedef enum logic [2:0] {
        WAITINIT,
        IDLE,
        SEND,
        WAIT,
        HOLD
    } state_t;

    state_t             state;
    state_t             stateNext;
    logic [CNT_W-1:0]   cnt;
    logic               volDirty;
    logic               muteDirty;
    logic               curIsMute;
    logic [6:0]         regQ;
    logic [8:0]         dataQ;

    logic               sendNow;
    logic               loadMute;
    logic               loadVol;
    logic               cntClr;
    logic               doneOk;
    logic               timedOut;
    logic               initLost;
    logic               volChange;

    // Saturating step in 8 bits so a step past VOL_MAX clamps instead of wrapping.
    function automatic logic [6:0] stepUp(input logic [6:0] cur);
        logic [7:0] sum;
        sum = {1'b0, cur} + {1'b0, VOL_STEP};
        if (sum > {1'b0, VOL_MAX})
            stepUp = VOL_MAX;
        else
            stepUp = sum[6:0];
    endfunction

    function automatic logic [6:0] stepDown(input logic [6:0] cur);
        if ({1'b0, cur} < ({1'b0, VOL_MIN} + {1'b0, VOL_STEP}))
            stepDown = VOL_MIN;
        else
            stepDown = cur - VOL_STEP;
    endfunction

    assign volChange         = volUp ^ volDown;
    assign busy              = (state == SEND) || (state == WAIT) || (state == HOLD);
    assign wr.manualSend     = sendNow;
    assign wr.manualRegister = regQ;
    assign wr.manualData     = dataQ;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= WAITINIT;
        else
            state <= stateNext;
    end

    // Losing initDone outside WAITINIT overrides everything, including a pending send.
    always_comb begin
        stateNext = state;
        sendNow   = 1'b0;
        loadMute  = 1'b0;
        loadVol   = 1'b0;
        cntClr    = 1'b0;
        doneOk    = 1'b0;
        timedOut  = 1'b0;
        initLost  = 1'b0;
        if ((state != WAITINIT) && !initDone) begin
            initLost  = 1'b1;
            stateNext = WAITINIT;
        end else begin
            case (state)
                WAITINIT: begin
                    if (initDone)
                        stateNext = IDLE;
                end
                IDLE: begin
                    if (muteDirty) begin
                        loadMute  = 1'b1;
                        stateNext = SEND;
                    end else if (volDirty) begin
                        loadVol   = 1'b1;
                        stateNext = SEND;
                    end
                end
                SEND: begin
                    sendNow   = 1'b1;
                    cntClr    = 1'b1;
                    stateNext = WAIT;
                end
                WAIT: begin
                    if ((cnt != '0) && wr.manualDone) begin
                        doneOk    = 1'b1;
                        cntClr    = 1'b1;
                        stateNext = HOLD;
                    end else if (cnt == TIMEOUT_LAST) begin
                        timedOut  = 1'b1;
                        cntClr    = 1'b1;
                        stateNext = HOLD;
                    end
                end
                HOLD: begin
                    if (cnt == HOLDOFF_LAST)
                        stateNext = IDLE;
                end
                default: stateNext = WAITINIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (cntClr)
            cnt <= '0;
        else if ((state == WAIT) || (state == HOLD))
            cnt <= cnt + 1'b1;
    end

    // A new pulse in the load cycle re-arms the flag, so the newer value still gets written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            volume    <= VOL_DEFAULT;
            muted     <= 1'b0;
            volDirty  <= 1'b1;
            muteDirty <= 1'b0;
        end else begin
            if (volUp && !volDown)
                volume <= stepUp(volume);
            else if (volDown && !volUp)
                volume <= stepDown(volume);
            muted     <= muted ^ muteToggle;
            volDirty  <= initLost | volChange | (timedOut & ~curIsMute) | (volDirty & ~loadVol);
            muteDirty <= initLost | muteToggle | (timedOut & curIsMute) | (muteDirty & ~loadMute);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regQ      <= '0;
            dataQ     <= '0;
            curIsMute <= 1'b0;
        end else if (loadMute) begin
            regQ      <= REG_MUTE;
            dataQ     <= {5'b0, muted, 3'b0};
            curIsMute <= 1'b1;
        end else if (loadVol) begin
            regQ      <= REG_VOLUME;
            dataQ     <= {1'b1, ZC_BIT, volume};
            curIsMute <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            wrError <= 1'b0;
        else if (timedOut)
            wrError <= 1'b1;
        else if (doneOk)
            wrError <= 1'b0;
    end

endmodule

// File: doc/codec_volume_ctrl.md
Name: codec_volume_ctrl

Overview:
- Upstream control stage for the codec init/manual-write block.
- Turns user volume-up, volume-down and mute-toggle pulses into single I2C register writes, using that block's manual-send handshake (send pulse / register / data / done pulse).
- Holds the current headphone volume and mute state, and merges rapid user changes so the latest value is always written.
- Never issues a write before codec initialisation reports done.

Parameters:
- VOL_DEFAULT, 7'h79, volume after reset (0 dB).
- VOL_MIN, 7'h30, lowest allowed volume code (codec mute floor).
- VOL_MAX, 7'h7F, highest allowed volume code (+6 dB).
- VOL_STEP, 2, code change per up/down pulse.
- HOLDOFF, 50000, minimum idle clk cycles between end of one write and start of the next.
- TIMEOUT, 2000000, maximum clk cycles to wait for manualDone before aborting.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- initDone  in  1  codec init complete (level)
- volUp  in  1  one-cycle pulse, volume up
- volDown  in  1  one-cycle pulse, volume down
- muteToggle  in  1  one-cycle pulse, toggle mute
- manualSend  out  1  one-cycle pulse requesting a write
- manualRegister  out  7  codec register address
- manualData  out  9  codec register data
- manualDone  in  1  one-cycle pulse, write complete
- volume  out  7  current volume code
- muted  out  1  current mute state
- busy  out  1  high in SEND, WAIT and HOLD
- wrError  out  1  sticky timeout flag

Behaviour:
- Reset values:
  - volume = VOL_DEFAULT, muted = 0.
  - manualSend = 0, manualRegister = 0, manualData = 0.
  - busy = 0, wrError = 0.
  - volDirty = 1 (pushes the default volume after init), muteDirty = 0.
  - FSM in WAITINIT.
- Input pulses are registered the same cycle they are seen, in any FSM state:
  - volUp: volume = min(volume + VOL_STEP, VOL_MAX); sets volDirty. Compute in 8 bits, then clamp. No wrap.
  - volDown: volume = max(volume - VOL_STEP, VOL_MIN); sets volDirty. Compare before subtracting. No underflow.
  - volUp and volDown in the same cycle: both ignored, no dirty change.
  - muteToggle: muted inverts; sets muteDirty. May coincide with up or down; both take effect.
  - A pulse at a clamp limit still sets volDirty.
- Write encodings:
  - Volume: manualRegister = 7'h02, manualData = {1'b1 (LRHPBOTH), ZC bit, volume}.
  - Mute: manualRegister = 7'h05, manualData = {5'b0, muted, 3'b0} (DACMU), i.e. 9'h008 when muted, 9'h000 when not.
- FSM:
  - WAITINIT: stay until initDone = 1, then go to IDLE.
  - IDLE: if muteDirty, load the mute write; else if volDirty, load the volume write. Clear the chosen dirty flag, go to SEND. Mute has priority.
  - SEND: manualSend = 1 for exactly one cycle; outputs hold their loaded values. Go to WAIT and clear the timeout counter.
  - WAIT: manualDone is ignored in the first WAIT cycle.
    - On manualDone: clear wrError, go to HOLD.
    - If the counter reaches TIMEOUT: set wrError, re-set the dirty flag of the aborted write, go to HOLD.
  - HOLD: count HOLDOFF cycles, then go to IDLE.
- manualRegister and manualData stay stable from load until the next load.
- Changes during SEND, WAIT or HOLD re-set dirty flags. Several changes collapse into one follow-up write carrying the latest value.
- initDone falling in any state: go to WAITINIT at once, drop manualSend, set volDirty and muteDirty. State is re-pushed after re-init.
- Reset mid-operation: all registers return to reset values immediately. No partial handshake continues.
- Latency: a pulse in IDLE leads to manualSend 2 cycles later (load cycle, then SEND).

Optional Feature:
- Macro VOLCTRL_ZEROCROSS_EN.
  - Defined: volume writes set data bit 7 (LZCEN), so the codec changes gain at zero crossings.
  - Undefined: bit 7 = 0, gain changes immediately.
- Mute writes are unaffected either way.

Test Plan:
- Reset, hold initDone = 0 for 100 cycles: no manualSend. Raise initDone: one write with register 7'h02, data 9'h179 (9'h1F9 with VOLCTRL_ZEROCROSS_EN); manualDone returned; busy goes low after HOLDOFF.
- 10 volDown pulses back-to-back during HOLD: exactly one further write, data 9'h165; volume = 7'h65.
- From volume 7'h7E, one volUp: volume = 7'h7F, write data 9'h17F. Another volUp: volume stays 7'h7F, one write of the same value.
- muteToggle and volUp in the same idle cycle: mute write (7'h05, 9'h008) goes out first, then the volume write; muted = 1.
- Never return manualDone: wrError = 1 after TIMEOUT cycles. Return manualDone on the retry: wrError = 0, and the same data is resent.
- Drop initDone during WAIT: manualSend stays 0 until initDone rises again, then the mute write is followed by the volume write.
